// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Circular FIFO between the instruction fetch response port and the decoder.
//   Entries leave in the order they were pushed. A flush discards all entries
//   synchronously. An asynchronous active-low reset clears the queue.
//
// Build option:
//   INSTR_FETCH_QUEUE_BYPASS_EN
//     When this macro is defined and the queue is empty, an incoming response
//     is presented to the decoder in the same cycle. If the decoder consumes it
//     in that cycle, it is not stored.
//     When the macro is undefined, the mem_* inputs have no combinational path
//     to the dec_* outputs, and a pushed entry is visible one cycle after the
//     push edge.
//
// Parameters
//   DEPTH : number of entries (power of two, >= 2)
//   XLEN  : PC width
//
// Ports
//   clk_i        : clock, rising edge
//   arst_ni      : asynchronous active-low reset
//   flush_i      : discard all buffered entries; drops a same-cycle push
//   mem_valid_i  : fetch response valid
//   mem_pc_i     : PC of the fetched instruction
//   mem_code_i   : fetched instruction word
//   mem_ready_o  : queue can accept a response (count_o < DEPTH)
//   dec_valid_o  : head entry valid toward the decoder
//   dec_pc_o     : PC of the head entry
//   dec_code_o   : instruction word of the head entry
//   dec_ready_i  : decoder consumes the head entry
//   count_o      : number of stored entries
module instr_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 64
) (
  input  logic                     clk_i,
  input  logic                     arst_ni,
  input  logic                     flush_i,
  input  logic                     mem_valid_i,
  input  logic [XLEN-1:0]          mem_pc_i,
  input  logic [31:0]              mem_code_i,
  output logic                     mem_ready_o,
  output logic                     dec_valid_o,
  output logic [XLEN-1:0]          dec_pc_o,
  output logic [31:0]              dec_code_o,
  input  logic                     dec_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [31:0]     code_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic empty;
  logic push;   // response accepted by the handshake
  logic store;  // accepted response is written into the array
  logic pop;    // stored head entry consumed

  assign empty       = (count_q == '0);
  // The ready signal depends only on the registered count, so it has no
  // combinational path from dec_ready_i.
  assign mem_ready_o = (count_q < CW'(DEPTH));
  assign count_o     = count_q;

  always_comb begin
    dec_valid_o = !empty && !flush_i;
    dec_pc_o    = pc_mem_q[rd_ptr_q];
    dec_code_o  = code_mem_q[rd_ptr_q];
    push        = mem_valid_i && mem_ready_o && !flush_i;
    store       = push;
    pop         = !empty && !flush_i && dec_ready_i;
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
    if (empty && !flush_i && mem_valid_i) begin
      dec_valid_o = 1'b1;
      dec_pc_o    = mem_pc_i;
      dec_code_o  = mem_code_i;
      // If the decoder takes the word straight from the bus, it never
      // occupies a slot.
      store       = push && !dec_ready_i;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointer width equals log2(DEPTH), so the +1 wraps naturally.
      if (store) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
      case ({store, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The storage array is not reset. Its contents cannot be observed while
  // the queue is empty.
  always_ff @(posedge clk_i) begin
    if (store) begin
      pc_mem_q[wr_ptr_q]   <= mem_pc_i;
      code_mem_q[wr_ptr_q] <= mem_code_i;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned XLEN  = 64;

  logic            clk_i;
  logic            arst_ni;
  logic            flush_i;
  logic            mem_valid_i;
  logic [XLEN-1:0] mem_pc_i;
  logic [31:0]     mem_code_i;
  logic            mem_ready_o;
  logic            dec_valid_o;
  logic [XLEN-1:0] dec_pc_o;
  logic [31:0]     dec_code_o;
  logic            dec_ready_i;
  logic [2:0]      count_o;

  int checks;
  int failures;

  instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .flush_i     (flush_i),
    .mem_valid_i (mem_valid_i),
    .mem_pc_i    (mem_pc_i),
    .mem_code_i  (mem_code_i),
    .mem_ready_o (mem_ready_o),
    .dec_valid_o (dec_valid_o),
    .dec_pc_o    (dec_pc_o),
    .dec_code_o  (dec_code_o),
    .dec_ready_i (dec_ready_i),
    .count_o     (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_one(input logic [63:0] pc, input logic [31:0] code);
    mem_valid_i = 1'b1;
    mem_pc_i    = pc;
    mem_code_i  = code;
    tick();
    mem_valid_i = 1'b0;
  endtask

  logic [63:0] push_pc;
  logic [63:0] head_pc;

  initial begin
    checks      = 0;
    failures    = 0;
    arst_ni     = 1'b0;
    flush_i     = 1'b0;
    mem_valid_i = 1'b0;
    mem_pc_i    = '0;
    mem_code_i  = '0;
    dec_ready_i = 1'b0;

    // Reset state
    #2;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_dec_valid", 64'(dec_valid_o), 64'd0);
    check("rst_mem_ready", 64'(mem_ready_o), 64'd1);
    #10 arst_ni = 1'b1;
    tick();

    // Single push, decoder stalled
    mem_valid_i = 1'b1;
    mem_pc_i    = 64'h1000;
    mem_code_i  = 32'h0000_0013;
    #1;
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
    check("p1_bypass_valid", 64'(dec_valid_o), 64'd1);
    check("p1_bypass_pc", dec_pc_o, 64'h1000);
`else
    check("p1_no_comb_path", 64'(dec_valid_o), 64'd0);
`endif
    tick();
    mem_valid_i = 1'b0;
    #1;
    check("p1_valid", 64'(dec_valid_o), 64'd1);
    check("p1_pc", dec_pc_o, 64'h1000);
    check("p1_code", 64'(dec_code_o), 64'h13);
    check("p1_count", 64'(count_o), 64'd1);
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;
    check("p1_drain_count", 64'(count_o), 64'd0);
    check("p1_drain_valid", 64'(dec_valid_o), 64'd0);

    // Fill to full, then one more response held
    for (int i = 0; i < 4; i++) begin
      mem_valid_i = 1'b1;
      mem_pc_i    = 64'(4 * i);
      mem_code_i  = 32'h100 + 32'(i);
      #1;
      check("fill_ready", 64'(mem_ready_o), 64'd1);
      tick();
    end
    mem_pc_i   = 64'h10;
    mem_code_i = 32'h104;
    #1;
    check("full_ready", 64'(mem_ready_o), 64'd0);
    check("full_count", 64'(count_o), 64'd4);
    tick();
    check("held_count", 64'(count_o), 64'd4);
    check("held_head_pc", dec_pc_o, 64'h0);
    dec_ready_i = 1'b1;
    check("pop0_pc", dec_pc_o, 64'h0);
    check("pop0_code", 64'(dec_code_o), 64'h100);
    tick();
    check("pop0_count", 64'(count_o), 64'd3);
    check("pop1_pc", dec_pc_o, 64'h4);
    tick();
    mem_valid_i = 1'b0;
    check("accept_held_count", 64'(count_o), 64'd3);
    check("pop2_pc", dec_pc_o, 64'h8);
    tick();
    check("pop3_pc", dec_pc_o, 64'hC);
    tick();
    check("pop4_pc", dec_pc_o, 64'h10);
    check("pop4_code", 64'(dec_code_o), 64'h104);
    tick();
    dec_ready_i = 1'b0;
    check("fill_drain_count", 64'(count_o), 64'd0);

    // Steady push+pop at count 2
    push_pc = 64'h100;
    head_pc = 64'h100;
    push_one(push_pc, 32'h0);
    push_pc += 64'd4;
    push_one(push_pc, 32'h0);
    push_pc += 64'd4;
    check("stream_start_count", 64'(count_o), 64'd2);
    for (int i = 0; i < 10; i++) begin
      mem_valid_i = 1'b1;
      mem_pc_i    = push_pc;
      mem_code_i  = 32'(i);
      dec_ready_i = 1'b1;
      #1;
      check("stream_head_pc", dec_pc_o, head_pc);
      tick();
      push_pc += 64'd4;
      head_pc += 64'd4;
      check("stream_count", 64'(count_o), 64'd2);
    end
    mem_valid_i = 1'b0;
    #1;
    check("stream_tail0_pc", dec_pc_o, head_pc);
    tick();
    head_pc += 64'd4;
    check("stream_tail1_pc", dec_pc_o, head_pc);
    tick();
    dec_ready_i = 1'b0;
    check("stream_drain_count", 64'(count_o), 64'd0);

    // Flush with a simultaneous push and pop
    push_one(64'h500, 32'h1);
    push_one(64'h504, 32'h2);
    push_one(64'h508, 32'h3);
    flush_i     = 1'b1;
    mem_valid_i = 1'b1;
    mem_pc_i    = 64'h2000;
    mem_code_i  = 32'hDEAD;
    dec_ready_i = 1'b1;
    #1;
    check("flush_cycle_valid", 64'(dec_valid_o), 64'd0);
    check("flush_cycle_ready", 64'(mem_ready_o), 64'd1);
    tick();
    flush_i     = 1'b0;
    mem_valid_i = 1'b0;
    dec_ready_i = 1'b0;
    #1;
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid", 64'(dec_valid_o), 64'd0);
    push_one(64'h600, 32'h6);
    check("post_flush_pc", dec_pc_o, 64'h600);
    check("post_flush_count", 64'(count_o), 64'd1);
    dec_ready_i = 1'b1;
    tick();
    dec_ready_i = 1'b0;

    // Asynchronous reset mid-cycle
    push_one(64'h700, 32'h7);
    push_one(64'h704, 32'h7);
    push_one(64'h708, 32'h7);
    check("pre_arst_count", 64'(count_o), 64'd3);
    arst_ni = 1'b0;
    #1;
    check("arst_count", 64'(count_o), 64'd0);
    check("arst_valid", 64'(dec_valid_o), 64'd0);
    check("arst_ready", 64'(mem_ready_o), 64'd1);
    #2 arst_ni = 1'b1;
    #1;
    check("arst_release_count", 64'(count_o), 64'd0);
    tick();
    check("arst_after_edge_valid", 64'(dec_valid_o), 64'd0);

    // Empty queue, push with the decoder ready
    mem_valid_i = 1'b1;
    mem_pc_i    = 64'h3000;
    mem_code_i  = 32'h0000_0033;
    dec_ready_i = 1'b1;
    #1;
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
    check("byp_valid", 64'(dec_valid_o), 64'd1);
    check("byp_pc", dec_pc_o, 64'h3000);
    check("byp_code", 64'(dec_code_o), 64'h33);
    tick();
    mem_valid_i = 1'b0;
    #1;
    check("byp_count", 64'(count_o), 64'd0);
    check("byp_after_valid", 64'(dec_valid_o), 64'd0);
`else
    check("nobyp_valid", 64'(dec_valid_o), 64'd0);
    tick();
    mem_valid_i = 1'b0;
    #1;
    check("nobyp_count", 64'(count_o), 64'd1);
    check("nobyp_pc", dec_pc_o, 64'h3000);
    tick();
    check("nobyp_drain_count", 64'(count_o), 64'd0);
`endif
    dec_ready_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
